rc4_stream_encryptor: RTL and testbench
=======================================

Name: rc4_stream_encryptor

Overview:
- Transmit-side counterpart of the RC4 decrypt/crack datapath.
- Takes a 24-bit secret key and a stream of plaintext bytes, and runs KSA then PRGA against an external 256x8 S-memory.
- Emits ciphertext bytes over a valid/ready handshake, for loading into the encrypted-message ROM image or for on-board loopback tests of the cracker.

Parameters:
- KEY_BYTES, 3, key length in bytes; key byte n = key[8*(KEY_BYTES-n)-1 -: 8], so byte 0 is the MSB byte.
- MSG_LEN, 32, number of bytes per message (0..255).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse that begins a message; ignored while busy
- key  input  8*KEY_BYTES  secret key, sampled on accepted start
- pt_data  input  8  plaintext byte
- pt_valid  input  1  plaintext byte available
- pt_ready  output  1  encryptor accepts plaintext this cycle
- ct_data  output  8  ciphertext byte
- ct_valid  output  1  ciphertext byte available
- ct_ready  input  1  sink accepts ciphertext
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after the last ciphertext handshake
- s_addr  output  8  S-memory address
- s_wdata  output  8  S-memory write data
- s_wren  output  1  S-memory write enable
- s_rdata  input  8  S-memory read data; valid the cycle after s_addr is presented

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; i=j=0; byte count 0.
- Reset mid-operation: return to IDLE immediately. S-memory contents are then undefined, and the next start reinitialises them.
- IDLE:
  - start latches key, clears i/j/count, sets busy, goes to INIT.
  - start while busy is ignored.
- INIT (256 cycles): s_wren=1, s_addr=s_wdata=i, i++. After i=255, wrap to i=0, j=0 and go to KSA.
- KSA (6 cycles per i, 1536 cycles total), states:
  - K_RD_I: addr=i.
  - K_LAT_I: si=s_rdata.
  - K_RD_J: j=j+si+key_byte[i mod KEY_BYTES], addr = new j.
  - K_LAT_J: sj=s_rdata.
  - K_WR_I: write S[i]=sj.
  - K_WR_J: write S[j]=si; i++. When i wraps 255->0, set i=0, j=0 and go to P_ACCEPT.
- Arithmetic: all index arithmetic is mod 256 (8-bit wrap). i==j swaps are legal and leave S unchanged.
- Latency: first pt_ready is asserted exactly 1792 cycles after the accepted start cycle.
- PRGA, per byte:
  - P_ACCEPT: pt_ready=1. On pt_valid&pt_ready, latch pt and set i=i+1.
  - P_RD_I / P_LAT_I: read si.
  - P_RD_J / P_LAT_J: j=j+si, read sj.
  - P_WR_I: write S[i]=sj.
  - P_WR_J: write S[j]=si.
  - P_RD_K: addr=si+sj.
  - P_LAT_K: ct_data = pt ^ s_rdata.
  - P_OUT: ct_valid=1. ct_data is held stable until ct_ready.
- After the handshake in P_OUT:
  - count++.
  - If count==MSG_LEN, go to DONE; else go to P_ACCEPT.
- Backpressure: ct_valid never drops without ct_ready. pt_ready is low in every state except P_ACCEPT.
- Minimum PRGA cost is 10 cycles per byte with pt_valid and ct_ready held high.
- DONE: done=1 for one cycle, busy=0, return to IDLE. S keeps its final state.
- MSG_LEN=0: go from the end of KSA directly to DONE.
- s_wren is high only in INIT, K_WR_*, P_WR_*. s_addr is don't-care when the block is not reading or writing.

Decomposition:
- Package rc4_pkg:
  - byte_t (8-bit) typedef.
  - FSM state enum.
  - Constants S_SIZE=256, INIT_CYCLES=256, KSA_CYCLES_PER_I=6.
- One natural sub-module, rc4_swap_unit. It sequences RD_I/LAT_I/RD_J/LAT_J/WR_I/WR_J on start_swap with a j_increment input, and returns si, sj and swap_done. KSA and PRGA share it; the top FSM owns IDLE/INIT/ACCEPT/K/OUT/DONE.

Test Plan:
- Standard vector: KEY_BYTES=3, MSG_LEN=9, key=24'h4B6579, plaintext "Plaintext" (50 6C 61 69 6E 74 65 78 74) -> ct stream BB F3 16 E8 D9 40 AF 0A D3, then one done pulse.
- Latency and INIT: start at cycle T -> pt_ready first high at T+1792; during INIT, s_wren=1 with s_addr==s_wdata, stepping 0..255.
- Backpressure: hold ct_ready=0 for 20 cycles on byte 3 of the vector -> ct_valid stays 1, ct_data stays E8, pt_ready stays 0; stream resumes correctly on release.
- Random pt_valid/ct_ready throttling over a 32-byte message with key 24'h000000 -> output matches the reference model byte-for-byte; busy is continuous; done pulses exactly once.
- Reset mid-KSA (cycle T+900) then a new start with key=24'h4B6579 -> all outputs are 0 during reset, and the subsequent stream equals the vector.
- start pulses while busy are ignored (output unchanged); MSG_LEN=0 -> done at T+1792 with no pt_ready ever asserted.

Source files
------------

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types, states and constants for the RC4 stream encryptor
package rc4_pkg;
    typedef logic [7:0] byte_t;
    localparam int S_SIZE = 256;
    localparam int INIT_CYCLES = 256;
    localparam int KSA_CYCLES_PER_I = 6;
    typedef enum logic [3:0] {
        ST_IDLE, ST_INIT, ST_KSA, ST_ACCEPT, ST_SWAP, ST_RD_K, ST_LAT_K, ST_OUT, ST_DONE
    } state_t;
    typedef enum logic [2:0] {
        SW_RD_I, SW_LAT_I, SW_RD_J, SW_LAT_J, SW_WR_I, SW_WR_J
    } swap_state_t;
endpackage

// File: rtl/rc4_swap_unit.sv
// rc4_swap_unit: reads S[i], advances j, reads S[j], then writes both back swapped
module rc4_swap_unit
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_swap,
    input  logic       j_clear,
    input  logic [7:0] i,
    input  logic [7:0] j_increment,
    input  logic [7:0] s_rdata,
    output logic [7:0] si,
    output logic [7:0] sj,
    output logic [7:0] s_addr,
    output logic [7:0] s_wdata,
    output logic       s_wren,
    output logic       swap_done
);
    swap_state_t state, state_next;
    byte_t j, j_new;

    // memory port drive and sequencing; SW_RD_I doubles as idle so back-to-back swaps take 6 cycles
    always_comb begin
        state_next = state;
        j_new = j + si + j_increment;
        s_addr = (state == SW_RD_J) ? j_new : (state == SW_WR_J) ? j : i;
        s_wdata = (state == SW_WR_J) ? si : sj;
        s_wren = (state == SW_WR_I) || (state == SW_WR_J);
        swap_done = (state == SW_WR_J);
        if (state == SW_RD_I)
            state_next = start_swap ? SW_LAT_I : SW_RD_I;
        else if (state == SW_WR_J)
            state_next = SW_RD_I;
        else
            state_next = swap_state_t'(state + 3'd1);
    end

    // sequence register, latched S[i]/S[j] and the running j index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SW_RD_I;
            si <= '0;
            sj <= '0;
            j <= '0;
        end else begin
            state <= state_next;
            if (state == SW_LAT_I)
                si <= s_rdata;
            if (state == SW_LAT_J)
                sj <= s_rdata;
            if (j_clear)
                j <= '0;
            else if (state == SW_RD_J)
                j <= j_new;
        end
    end
endmodule

// File: rtl/rc4_stream_encryptor.sv
// rc4_stream_encryptor: RC4 KSA + PRGA over an external S-memory, XORing plaintext into ciphertext
module rc4_stream_encryptor
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int MSG_LEN = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [7:0]             pt_data,
    input  logic                   pt_valid,
    output logic                   pt_ready,
    output logic [7:0]             ct_data,
    output logic                   ct_valid,
    input  logic                   ct_ready,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rdata
);
    state_t state, state_next;
    byte_t i, count, pt_r, si, sj, sw_addr, sw_wdata, key_byte;
    logic [8*KEY_BYTES-1:0] key_r;
    logic sw_wren, swap_done, start_swap, j_clear, last_i;
    int kidx;

    assign kidx = int'(i) % KEY_BYTES;
    assign key_byte = byte_t'(key_r >> (8 * (KEY_BYTES - 1 - kidx)));
    assign last_i = (i == byte_t'(S_SIZE - 1));

    rc4_swap_unit u_swap (
        .clk(clk),
        .reset(reset),
        .start_swap(start_swap),
        .j_clear(j_clear),
        .i(i),
        .j_increment((state == ST_KSA) ? key_byte : 8'h00),
        .s_rdata(s_rdata),
        .si(si),
        .sj(sj),
        .s_addr(sw_addr),
        .s_wdata(sw_wdata),
        .s_wren(sw_wren),
        .swap_done(swap_done)
    );

    // phase sequencing and all handshake / memory outputs; the swap unit owns the memory during KSA and PRGA swaps
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_INIT;
            ST_INIT:   if (i == byte_t'(INIT_CYCLES - 1)) state_next = ST_KSA;
            ST_KSA:    if (swap_done && last_i) state_next = (MSG_LEN == 0) ? ST_DONE : ST_ACCEPT;
            ST_ACCEPT: if (pt_valid) state_next = ST_SWAP;
            ST_SWAP:   if (swap_done) state_next = ST_RD_K;
            ST_RD_K:   state_next = ST_LAT_K;
            ST_LAT_K:  state_next = ST_OUT;
            ST_OUT:    if (ct_ready) state_next = (count == byte_t'(MSG_LEN - 1)) ? ST_DONE : ST_ACCEPT;
            default:   state_next = ST_IDLE;
        endcase
        start_swap = (state == ST_KSA) || (state == ST_SWAP);
        j_clear = ((state == ST_IDLE) && start) || ((state == ST_KSA) && swap_done && last_i);
        pt_ready = (state == ST_ACCEPT);
        ct_valid = (state == ST_OUT);
        busy = (state != ST_IDLE) && (state != ST_DONE);
        done = (state == ST_DONE);
        s_wren = (state == ST_INIT) || (start_swap && sw_wren);
        s_addr = (state == ST_INIT) ? i : start_swap ? sw_addr : (state == ST_RD_K) ? si + sj : 8'h00;
        s_wdata = (state == ST_INIT) ? i : start_swap ? sw_wdata : 8'h00;
    end

    // state, i, byte count, latched key/plaintext and the held ciphertext byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            i <= '0;
            count <= '0;
            key_r <= '0;
            pt_r <= '0;
            ct_data <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && start) begin
                key_r <= key;
                i <= '0;
                count <= '0;
            end
            if (state == ST_INIT || (state == ST_KSA && swap_done) || (pt_ready && pt_valid))
                i <= i + 8'd1;
            if (pt_ready && pt_valid)
                pt_r <= pt_data;
            if (state == ST_LAT_K)
                ct_data <= pt_r ^ s_rdata;
            if (ct_valid && ct_ready)
                count <= count + 8'd1;
        end
    end
endmodule

// File: tb/tb_rc4_stream_encryptor.sv
// tb_rc4_stream_encryptor: directed and randomized checks of the encryptor against a software RC4 model
module tb_rc4_stream_encryptor;
    localparam int NU = 3;

    logic clk = 0;
    logic reset [NU], start [NU], pt_valid [NU], pt_ready [NU], ct_valid [NU], ct_ready [NU];
    logic busy [NU], done [NU], s_wren [NU];
    logic [23:0] key [NU];
    logic [7:0] pt_data [NU], ct_data [NU], s_addr [NU], s_wdata [NU];

    int nvec = 0, nerr = 0;
    logic [7:0] ptq [$], got [$], ks [256];
    int dones, done_cyc, busy_drops, lat, hold_bad, init_bad;
    logic [7:0] held;
    logic [7:0] vec_pt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] vec_ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    always #5 clk = ~clk;

    for (genvar g = 0; g < NU; g++) begin : gen_u
        logic [7:0] mem [256];
        logic [7:0] rdata;
        always @(posedge clk) begin
            if (s_wren[g]) mem[s_addr[g]] <= s_wdata[g];
            rdata <= mem[s_addr[g]];
        end
        rc4_stream_encryptor #(.KEY_BYTES(3), .MSG_LEN(g == 0 ? 9 : g == 1 ? 32 : 0)) dut (
            .clk(clk), .reset(reset[g]), .start(start[g]), .key(key[g]),
            .pt_data(pt_data[g]), .pt_valid(pt_valid[g]), .pt_ready(pt_ready[g]),
            .ct_data(ct_data[g]), .ct_valid(ct_valid[g]), .ct_ready(ct_ready[g]),
            .busy(busy[g]), .done(done[g]), .s_addr(s_addr[g]), .s_wdata(s_wdata[g]),
            .s_wren(s_wren[g]), .s_rdata(rdata));
    end

    task automatic gen_ks(input logic [23:0] k, input int n);
        int s [256];
        int i, j, t;
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + s[x] + int'(k[8 * (2 - x % 3) +: 8])) % 256;
            t = s[x]; s[x] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        for (int x = 0; x < n; x++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks[x] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    task automatic load_vec();
        ptq.delete();
        for (int x = 0; x < 9; x++) ptq.push_back(vec_pt[x]);
    endtask

    task automatic drive(input int u, input logic [23:0] k, input int n, input bit rnd, input int hold, input bit nag);
        int sent, hc;
        got.delete();
        dones = 0; done_cyc = -1; busy_drops = 0; lat = -1; hold_bad = 0; init_bad = 0;
        sent = 0; hc = 0; held = 0;
        @(negedge clk);
        key[u] = k;
        start[u] = 1;
        @(negedge clk);
        start[u] = 0;
        key[u] = ~k;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc < 256 && (s_wren[u] !== 1 || s_addr[u] !== 8'(cyc) || s_wdata[u] !== 8'(cyc))) init_bad++;
            if (done[u] === 1) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (dones == 0 && busy[u] !== 1) busy_drops++;
            if (pt_ready[u] === 1 && lat < 0) lat = cyc;
            if (dones > 0 && cyc >= done_cyc + 4) break;
            pt_valid[u] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ct_ready[u] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pt_data[u] = sent < n ? ptq[sent] : 8'h00;
            start[u] = nag && dones == 0 && (cyc == 100 || cyc == 1850);
            if (hc == 0 && hold == got.size() && ct_valid[u] === 1) begin
                held = ct_data[u];
                hc = 1;
            end else if (hc > 0 && hc < 21) begin
                hc++;
                if (ct_valid[u] !== 1 || ct_data[u] !== held || pt_ready[u] !== 0) hold_bad++;
            end
            if (hc > 0 && hc < 21) ct_ready[u] = 0;
            if (pt_ready[u] === 1 && pt_valid[u]) sent++;
            if (ct_valid[u] === 1 && ct_ready[u]) got.push_back(ct_data[u]);
            @(negedge clk);
        end
        pt_valid[u] = 0;
        ct_ready[u] = 0;
        start[u] = 0;
    endtask

    task automatic test_reset();
        for (int u = 0; u < NU; u++) reset[u] = 1;
        repeat (2) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            nvec++;
            if ({pt_ready[u], ct_valid[u], busy[u], done[u], s_wren[u], ct_data[u], s_addr[u], s_wdata[u]} !== 29'd0) begin
                nerr++;
                $display("FAIL reset_outputs unit %0d got %h want 0", u,
                    {pt_ready[u], ct_valid[u], busy[u], done[u], s_wren[u], ct_data[u], s_addr[u], s_wdata[u]});
            end
        end
        for (int u = 0; u < NU; u++) reset[u] = 0;
        @(negedge clk);
    endtask

    task automatic test_vector();
        load_vec();
        drive(0, 24'h4B6579, 9, 0, -1, 0);
        nvec++; if (lat !== 1792) begin nerr++; $display("FAIL vector_latency got %0d want 1792", lat); end
        nvec++; if (init_bad !== 0) begin nerr++; $display("FAIL init_writes got %0d bad cycles want 0", init_bad); end
        nvec++; if (dones !== 1) begin nerr++; $display("FAIL vector_done got %0d pulses want 1", dones); end
        nvec++; if (busy_drops !== 0) begin nerr++; $display("FAIL vector_busy got %0d drops want 0", busy_drops); end
        nvec++; if (got.size() !== 9) begin nerr++; $display("FAIL vector_count got %0d want 9", got.size()); end
        for (int x = 0; x < got.size() && x < 9; x++) begin
            nvec++;
            if (got[x] !== vec_ct[x]) begin nerr++; $display("FAIL vector_byte %0d got %h want %h", x, got[x], vec_ct[x]); end
        end
    endtask

    task automatic test_backpressure();
        load_vec();
        drive(0, 24'h4B6579, 9, 0, 3, 0);
        nvec++; if (held !== 8'hE8) begin nerr++; $display("FAIL bp_held_byte got %h want e8", held); end
        nvec++; if (hold_bad !== 0) begin nerr++; $display("FAIL bp_hold got %0d unstable cycles want 0", hold_bad); end
        nvec++; if (got.size() !== 9) begin nerr++; $display("FAIL bp_count got %0d want 9", got.size()); end
        for (int x = 0; x < got.size() && x < 9; x++) begin
            nvec++;
            if (got[x] !== vec_ct[x]) begin nerr++; $display("FAIL bp_byte %0d got %h want %h", x, got[x], vec_ct[x]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] k;
        for (int r = 0; r < 2; r++) begin
            k = (r == 0) ? 24'h000000 : 24'($urandom);
            ptq.delete();
            for (int x = 0; x < 32; x++) ptq.push_back(8'($urandom));
            gen_ks(k, 32);
            drive(1, k, 32, 1, -1, 0);
            nvec++; if (lat !== 1792) begin nerr++; $display("FAIL rand_latency key %h got %0d want 1792", k, lat); end
            nvec++; if (dones !== 1) begin nerr++; $display("FAIL rand_done key %h got %0d want 1", k, dones); end
            nvec++; if (busy_drops !== 0) begin nerr++; $display("FAIL rand_busy key %h got %0d want 0", k, busy_drops); end
            nvec++; if (got.size() !== 32) begin nerr++; $display("FAIL rand_count key %h got %0d want 32", k, got.size()); end
            for (int x = 0; x < got.size() && x < 32; x++) begin
                nvec++;
                if (got[x] !== (ptq[x] ^ ks[x])) begin
                    nerr++;
                    $display("FAIL rand_byte key %h idx %0d got %h want %h", k, x, got[x], ptq[x] ^ ks[x]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        key[0] = 24'h123456;
        start[0] = 1;
        @(negedge clk);
        start[0] = 0;
        repeat (899) @(negedge clk);
        reset[0] = 1;
        #1;
        nvec++;
        if ({pt_ready[0], ct_valid[0], busy[0], done[0], s_wren[0], ct_data[0], s_addr[0], s_wdata[0]} !== 29'd0) begin
            nerr++;
            $display("FAIL midreset_outputs got %h want 0",
                {pt_ready[0], ct_valid[0], busy[0], done[0], s_wren[0], ct_data[0], s_addr[0], s_wdata[0]});
        end
        repeat (3) @(negedge clk);
        reset[0] = 0;
        load_vec();
        drive(0, 24'h4B6579, 9, 0, -1, 0);
        nvec++; if (got.size() !== 9) begin nerr++; $display("FAIL midreset_count got %0d want 9", got.size()); end
        for (int x = 0; x < got.size() && x < 9; x++) begin
            nvec++;
            if (got[x] !== vec_ct[x]) begin nerr++; $display("FAIL midreset_byte %0d got %h want %h", x, got[x], vec_ct[x]); end
        end
    endtask

    task automatic test_start_ignored();
        load_vec();
        drive(0, 24'h4B6579, 9, 0, -1, 1);
        nvec++; if (dones !== 1) begin nerr++; $display("FAIL ignore_done got %0d want 1", dones); end
        nvec++; if (got.size() !== 9) begin nerr++; $display("FAIL ignore_count got %0d want 9", got.size()); end
        for (int x = 0; x < got.size() && x < 9; x++) begin
            nvec++;
            if (got[x] !== vec_ct[x]) begin nerr++; $display("FAIL ignore_byte %0d got %h want %h", x, got[x], vec_ct[x]); end
        end
    endtask

    task automatic test_empty();
        ptq.delete();
        drive(2, 24'($urandom), 0, 0, -1, 0);
        nvec++; if (done_cyc !== 1792) begin nerr++; $display("FAIL empty_done_time got %0d want 1792", done_cyc); end
        nvec++; if (dones !== 1) begin nerr++; $display("FAIL empty_done got %0d want 1", dones); end
        nvec++; if (lat !== -1) begin nerr++; $display("FAIL empty_pt_ready got %0d want -1 (never)", lat); end
        nvec++; if (got.size() !== 0) begin nerr++; $display("FAIL empty_count got %0d want 0", got.size()); end
    endtask

    initial begin
        for (int u = 0; u < NU; u++) begin
            reset[u] = 1;
            start[u] = 0;
            key[u] = 0;
            pt_data[u] = 0;
            pt_valid[u] = 0;
            ct_ready[u] = 0;
        end
        test_reset();
        test_vector();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_start_ignored();
        test_empty();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
